jam_cost_fetch_sched: RTL and testbench
=======================================

Name: jam_cost_fetch_sched

Overview:
- Shared-resource scheduler for the single-port 8x8 job-assignment cost ROM (address W/J, combinational 7-bit Cost return).
- Accepts complete candidate permutations from NREQ permutation-search engines and arbitrates between them round-robin.
- For each granted permutation it sequences the 8 ROM reads, accumulates the total assignment cost, and returns the sum tagged with the requester id.

Parameters:
NREQ, 2, number of requesting engines (1..8)
IDW, 1, width of done_id; 2^IDW >= NREQ

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  synchronous, active-high reset
req  in  NREQ  per-requester request; hold with perm_in stable until ack
perm_in  in  NREQ*24  requester i in bits [i*24 +: 24]; job for worker w in bits [i*24+3*w +: 3]
ack  out  NREQ  one-cycle pulse, one-hot: request i accepted, perm captured
W  out  3  ROM worker address
J  out  3  ROM job address
Cost  in  7  ROM data for current W/J, valid in the same cycle
busy  out  1  high in FETCH and DONE
done  out  1  one-cycle pulse: sum/done_id valid
done_id  out  IDW  index of the requester whose sum is reported
sum  out  10  total cost of that permutation; holds until next done

Behaviour:
- Reset values (RST sampled high at an edge): state=IDLE; cnt=0; ptr=0; ack=0; done=0; done_id=0; sum=0; W=0; J=0; busy=0. Reset outranks every other event.
- Reset during FETCH or DONE aborts the operation: no done pulse, sum not updated, the captured permutation is discarded.
- State IDLE:
  - if any req bit is high at the edge, grant the first set bit searching ptr, ptr+1, ... modulo NREQ;
  - capture that perm_in slice and the index; ack[index]=1 for the next cycle only;
  - set ptr=(index+1) mod NREQ; acc=0; cnt=0; go to FETCH.
  - With no req, stay in IDLE.
- State FETCH, 8 cycles, cnt=0..7:
  - W=cnt, J=captured perm[3*cnt +: 3];
  - at each edge acc += Cost (zero-extended) and cnt increments;
  - at the edge with cnt=7, go to DONE.
- State DONE, 1 cycle: done=1, sum=final acc, done_id=granted index; next state IDLE.
- Outside FETCH, W=0 and J=0.
- Timing:
  - done is high in the 9th cycle after the accepting edge;
  - IDLE revisits at least once per operation, so the minimum period per permutation is 10 cycles.
- Request handshake:
  - req is evaluated only in IDLE; a req dropped before ack is simply never granted.
  - A requester still holding req after its ack is treated as a new request with whatever perm_in is then present.
- Arithmetic: maximum sum is 8*127=1016, which fits 10 bits; no overflow or saturation logic.
- The permutation is not validated: duplicate job values are fetched as given.

Test Plan:
1. Reset: hold RST 3 cycles -> ack=0, done=0, sum=0, done_id=0, W=J=0, busy=0.
2. Table cost[w][j]=(w==j)?100:1; req[0] with identity perm (job w for worker w) -> ack[0] one cycle; W/J run 0/0..7/7 on consecutive cycles; done 9 cycles after accept; sum=800, done_id=0.
3. Same table, req[1] with reversed perm (job 7-w) -> J runs 7..0; sum=8, done_id=1.
4. All ROM entries 127, any perm -> sum=1016, no wrap.
5. req=2'b11 held continuously with distinct perms after reset -> grants alternate 0,1,0,1 with ack pulses 10 cycles apart; each done_id matches its ack order; sums match each requester's perm.
6. RST asserted in the 4th FETCH cycle -> no done; after release with req[1] high, requester 1 is granted (ptr=0, req[0] low) and returns the correct full sum.

Source files
------------

// File: rtl/jam_cost_fetch_sched.sv
// Round-robin scheduler sharing the 8x8 job-assignment cost ROM between NREQ
// permutation-search engines; sums the 8 costs of each granted permutation.
module jam_cost_fetch_sched #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*24-1:0]   perm_in,
  output logic [NREQ-1:0]      ack,
  output logic [2:0]           W,
  output logic [2:0]           J,
  input  logic [6:0]           Cost,
  output logic                 busy,
  output logic                 done,
  output logic [IDW-1:0]       done_id,
  output logic [9:0]           sum
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [2:0]      cnt;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  gid;
  logic [23:0]     perm;
  logic [9:0]      acc;

  logic            grant_vld;
  logic [IDW-1:0]  grant_idx;
  logic [23:0]     grant_perm;

  // Search starts at ptr and wraps; shifts keep the selects width-clean.
  always_comb begin : arb
    int unsigned k;
    k          = 0;
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_perm = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k = (32'(ptr) + i) % NREQ;
      if (!grant_vld && ((req >> k) & NREQ'(1)) != '0) begin
        grant_vld  = 1'b1;
        grant_idx  = IDW'(k);
        grant_perm = 24'(perm_in >> (k * 24));
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_vld) state_nxt = S_FETCH;
      S_FETCH: if (cnt == 3'd7) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt     <= '0;
      ptr     <= '0;
      gid     <= '0;
      perm    <= '0;
      acc     <= '0;
      ack     <= '0;
      done    <= 1'b0;
      done_id <= '0;
      sum     <= '0;
    end else begin
      ack  <= '0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_vld) begin
            ack  <= NREQ'(1) << grant_idx;
            perm <= grant_perm;
            gid  <= grant_idx;
            ptr  <= IDW'((32'(grant_idx) + 1) % NREQ);
            acc  <= '0;
            cnt  <= '0;
          end
        end
        S_FETCH: begin
          acc <= acc + 10'(Cost);
          cnt <= cnt + 3'd1;
          // Final sum is registered on the last fetch edge so done/sum line up in DONE.
          if (cnt == 3'd7) begin
            sum     <= acc + 10'(Cost);
            done    <= 1'b1;
            done_id <= gid;
          end
        end
        default: ;
      endcase
    end
  end

  assign W    = (state == S_FETCH) ? cnt : 3'd0;
  assign J    = (state == S_FETCH) ? 3'(perm >> (32'(cnt) * 3)) : 3'd0;
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_jam_cost_fetch_sched.sv
// Directed + randomized bench for jam_cost_fetch_sched against a ROM-sum and
// round-robin reference model.
module tb_jam_cost_fetch_sched;

  localparam int unsigned NREQ = 2;
  localparam int unsigned IDW  = 1;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NREQ-1:0]   req;
  logic [NREQ*24-1:0] perm_in;
  logic [NREQ-1:0]   ack;
  logic [2:0]        W, J;
  logic [6:0]        Cost;
  logic              busy, done;
  logic [IDW-1:0]    done_id;
  logic [9:0]        sum;

  logic [6:0] rom [8][8];
  int ncmp  = 0;
  int nfail = 0;
  int mptr  = 0;

  jam_cost_fetch_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .CLK(CLK), .RST(RST), .req(req), .perm_in(perm_in), .ack(ack),
    .W(W), .J(J), .Cost(Cost), .busy(busy), .done(done),
    .done_id(done_id), .sum(sum)
  );

  assign Cost = rom[W][J];
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_sum(input logic [23:0] p);
    int s = 0;
    for (int w = 0; w < 8; w++) s += int'(rom[3'(w)][3'(p >> (3 * w))]);
    return s;
  endfunction

  function automatic int model_grant(input logic [NREQ-1:0] r);
    for (int i = 0; i < int'(NREQ); i++) begin
      int k;
      k = (mptr + i) % int'(NREQ);
      if (((r >> k) & 1) != 0) return k;
    end
    return -1;
  endfunction

  task automatic fill_rom(input int mode);
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++)
        case (mode)
          0: rom[w][j] = 7'd0;
          1: rom[w][j] = (w == j) ? 7'd100 : 7'd1;
          2: rom[w][j] = 7'd127;
          default: rom[w][j] = 7'($urandom_range(0, 127));
        endcase
  endtask

  // Waits (bounded) for the accept, then follows the whole operation.
  task automatic run_op(input int exp_idx, input logic [23:0] p,
                        input logic [NREQ-1:0] req_after, output int waited);
    int s;
    s = exp_sum(p);
    waited = 0;
    do begin
      @(negedge CLK);
      waited++;
    end while (ack === '0 && waited < 40);
    check("ack", 32'(ack), 32'd1 << exp_idx);
    if (ack === '0) return;
    mptr = (exp_idx + 1) % int'(NREQ);
    req = req_after;
    for (int w = 0; w < 8; w++) begin
      check("W", 32'(W), w);
      check("J", 32'(J), 32'(3'(p >> (3 * w))));
      check("done_early", 32'(done), 0);
      if (w == 1) check("ack_pulse", 32'(ack), 0);
      @(negedge CLK);
    end
    check("done", 32'(done), 1);
    check("done_id", 32'(done_id), exp_idx);
    check("sum", 32'(sum), s);
    check("busy_done", 32'(busy), 1);
    @(negedge CLK);
    check("done_pulse", 32'(done), 0);
    check("sum_hold", 32'(sum), s);
    check("busy_idle", 32'(busy), 0);
    check("WJ_idle", 32'({W, J}), 0);
  endtask

  initial begin
    int wt, idx, n;
    logic [23:0] pa, pb;
    RST = 1'b1; req = '0; perm_in = '0;
    fill_rom(0);

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_ack", 32'(ack), 0);
    check("rst_done", 32'(done), 0);
    check("rst_sum", 32'(sum), 0);
    check("rst_done_id", 32'(done_id), 0);
    check("rst_WJ", 32'({W, J}), 0);
    check("rst_busy", 32'(busy), 0);
    RST = 1'b0;
    mptr = 0;

    // Diagonal table, identity perm on requester 0
    fill_rom(1);
    perm_in = {24'o01234567, 24'o76543210};
    req = 2'b01;
    run_op(model_grant(req), 24'o76543210, 2'b00, wt);
    check("sum_identity", 32'(sum), 800);

    // Reversed perm on requester 1
    req = 2'b10;
    run_op(model_grant(req), 24'o01234567, 2'b00, wt);
    check("sum_reversed", 32'(sum), 8);

    // Saturated ROM: maximum sum without wrap
    fill_rom(2);
    pa = 24'($urandom());
    perm_in = {24'($urandom()), pa};
    req = 2'b01;
    run_op(model_grant(req), pa, 2'b00, wt);
    check("sum_max", 32'(sum), 1016);

    // Both requesters held after reset: strict alternation, 10-cycle spacing
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    mptr = 0;
    fill_rom(3);
    pa = 24'($urandom());
    do pb = 24'($urandom()); while (pb == pa);
    perm_in = {pb, pa};
    req = 2'b11;
    for (n = 0; n < 4; n++) begin
      run_op(n % 2, (n % 2) ? pb : pa, (n == 3) ? 2'b00 : 2'b11, wt);
      if (n > 0) check("ack_spacing", wt, 1);
    end

    // Randomized masks, perms and ROM contents against the model
    for (n = 0; n < 6; n++) begin
      fill_rom(3);
      perm_in = {24'($urandom()), 24'($urandom())};
      req = 2'($urandom_range(1, 3));
      idx = model_grant(req);
      run_op(idx, 24'(perm_in >> (idx * 24)), 2'b00, wt);
    end

    // Reset in the 4th FETCH cycle aborts; requester 1 then served fully
    fill_rom(3);
    pa = 24'($urandom());
    pb = 24'($urandom());
    perm_in = {pb, pa};
    req = 2'b01;
    wt = 0;
    do begin
      @(negedge CLK);
      wt++;
    end while (ack === '0 && wt < 40);
    check("abort_ack", 32'(ack), 1);
    req = 2'b00;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    req = 2'b10;
    for (n = 0; n < 2; n++) begin
      @(negedge CLK);
      check("abort_done", 32'(done), 0);
      check("abort_busy", 32'(busy), 0);
      check("abort_sum", 32'(sum), 0);
      check("abort_ack_low", 32'(ack), 0);
    end
    RST = 1'b0;
    mptr = 0;
    run_op(model_grant(req), pb, 2'b00, wt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
